// File: rtl/clock_set_sequencer_if.sv
// Bundle of the sequencer's request, clock-observation and button-drive lines.
// The slave modport is the sequencer; the master is whatever requests a set and
// provides the clock counters.
interface clock_set_sequencer_if;
  logic       start;
  logic       sel_alarm;
  logic [3:0] tgt_hrs;
  logic [5:0] tgt_min;
  logic       tgt_pm;
  logic [6:0] cur_hrs;
  logic [6:0] cur_min;
  logic       cur_pm;
  logic       Timeset;
  logic       Alarmset;
  logic       Hrsadv;
  logic       Minadv;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, sel_alarm, tgt_hrs, tgt_min, tgt_pm, cur_hrs, cur_min, cur_pm,
    input  Timeset, Alarmset, Hrsadv, Minadv, busy, done, err
  );

  modport slave (
    input  start, sel_alarm, tgt_hrs, tgt_min, tgt_pm, cur_hrs, cur_min, cur_pm,
    output Timeset, Alarmset, Hrsadv, Minadv, busy, done, err
  );
endinterface

// File: rtl/clock_set_sequencer.sv
// Scripted set-time / set-alarm driver for the 12-hour clock. Steps hours (which
// also walks through the PM toggle) until {pm, hrs} matches, then steps minutes,
// one advance pulse per two cycles, with a per-field step-limit abort.
module clock_set_sequencer #(
  parameter int unsigned STEP_LIMIT = 64
) (
  input logic                   Pulse,
  input logic                   Reset,
  clock_set_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StArm, StHchk, StHadv, StMchk, StMadv, StRel, StDone
  } state_e;

  localparam logic [6:0] Limit = 7'(STEP_LIMIT);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic [3:0] hrs_q, hrs_d;
  logic [5:0] min_q, min_d;
  logic       pm_q, pm_d;
  logic [6:0] hcnt_q, hcnt_d;
  logic [6:0] mcnt_q, mcnt_d;
  logic       abort_q, abort_d;
  logic       inv_q, inv_d;

  logic tgt_valid, hrs_match, min_match, mode_on;

  assign tgt_valid = (bus.tgt_hrs <= 4'd11) && (bus.tgt_min <= 6'd59);
  assign hrs_match = ({bus.cur_pm, bus.cur_hrs} == {pm_q, 3'b000, hrs_q});
  assign min_match = (bus.cur_min == {1'b0, min_q});

  // State and captured-target registers with synchronous reset.
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      hrs_q   <= 4'd0;
      min_q   <= 6'd0;
      pm_q    <= 1'b0;
      hcnt_q  <= 7'd0;
      mcnt_q  <= 7'd0;
      abort_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      pm_q    <= pm_d;
      hcnt_q  <= hcnt_d;
      mcnt_q  <= mcnt_d;
      abort_q <= abort_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state, target capture and step counting.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hrs_d   = hrs_q;
    min_d   = min_q;
    pm_d    = pm_q;
    hcnt_d  = hcnt_q;
    mcnt_d  = mcnt_q;
    abort_d = abort_q;
    inv_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (tgt_valid) begin
            state_d = StArm;
            sel_d   = bus.sel_alarm;
            hrs_d   = bus.tgt_hrs;
            min_d   = bus.tgt_min;
            pm_d    = bus.tgt_pm;
            abort_d = 1'b0;
          end else begin
            // Bad target: flag it for one cycle, never leave idle.
            inv_d = 1'b1;
          end
        end
      end
      StArm: begin
        state_d = StHchk;
        hcnt_d  = 7'd0;
      end
      StHchk: begin
        if (hrs_match) begin
          state_d = StMchk;
          mcnt_d  = 7'd0;
        end else if (hcnt_q == Limit) begin
          state_d = StRel;
          abort_d = 1'b1;
        end else begin
          state_d = StHadv;
        end
      end
      StHadv: begin
        state_d = StHchk;
        hcnt_d  = hcnt_q + 7'd1;
      end
      StMchk: begin
        if (min_match) begin
          state_d = StRel;
        end else if (mcnt_q == Limit) begin
          state_d = StRel;
          abort_d = 1'b1;
        end else begin
          state_d = StMadv;
        end
      end
      StMadv: begin
        state_d = StMchk;
        mcnt_d  = mcnt_q + 7'd1;
      end
      StRel:   state_d = abort_q ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    mode_on = (state_q == StArm) || (state_q == StHchk) || (state_q == StHadv) ||
              (state_q == StMchk) || (state_q == StMadv);
    bus.Timeset  = mode_on && !sel_q;
    bus.Alarmset = mode_on && sel_q;
    bus.Hrsadv   = (state_q == StHadv);
    bus.Minadv   = (state_q == StMadv);
    bus.busy     = mode_on || (state_q == StRel);
    bus.done     = (state_q == StDone);
    bus.err      = inv_q || ((state_q == StRel) && abort_q);
  end

endmodule
